// File: rtl/clk_reset_sequencer.sv
// rtl/clk_reset_sequencer.sv - PLL lock qualification, core reset sequencing and CPU clock-enable generation.
module clk_reset_sequencer #(
  parameter int LOCK_STABLE = 256,
  parameter int RESET_HOLD  = 16,
  parameter int CE_DIV      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       core_reset,
  output logic       core_ready,
  output logic       ce_cpu,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] state
);

  localparam int CNT_MAX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CE_DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      loss_q, loss_d;
  logic            ce_d;
  logic            sync1, locked_s;
  logic [7:0]      loss_inc;

  assign loss_inc      = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
  assign state         = state_q;
  assign lock_loss_cnt = loss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      div_q      <= '0;
      loss_q     <= 8'd0;
      core_reset <= 1'b1;
      core_ready <= 1'b0;
      ce_cpu     <= 1'b0;
    end else begin
      sync1      <= pll_locked;
      locked_s   <= sync1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      loss_q     <= loss_d;
      // Outputs follow the next state so they change on the same edge as the transition.
      core_reset <= (state_d != RUN);
      core_ready <= (state_d == RUN);
      ce_cpu     <= ce_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    loss_d  = loss_q;
    ce_d    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STAB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          loss_d  = loss_inc;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          div_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          loss_d  = loss_inc;
        end else begin
          ce_d  = (div_q == DIV_LAST);
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// tb/tb_clk_reset_sequencer.sv - self-checking bench for clk_reset_sequencer, two parameter sets in parallel.
module tb_clk_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       core_reset_a, core_ready_a, ce_cpu_a;
  logic [7:0] lock_loss_cnt_a;
  logic [1:0] state_a;
  logic       core_reset_b, core_ready_b, ce_cpu_b;
  logic [7:0] lock_loss_cnt_b;
  logic [1:0] state_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: run length of consecutive high synchronised samples decides everything.
  int ls_p[2] = '{4, 1};
  int rh_p[2] = '{2, 1};
  int cd_p[2] = '{4, 1};
  int run[2];
  int llc[2];
  logic p1, p2;

  always #5 clk = ~clk;

  clk_reset_sequencer #(.LOCK_STABLE(4), .RESET_HOLD(2), .CE_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .core_reset(core_reset_a), .core_ready(core_ready_a), .ce_cpu(ce_cpu_a),
    .lock_loss_cnt(lock_loss_cnt_a), .state(state_a)
  );

  clk_reset_sequencer #(.LOCK_STABLE(1), .RESET_HOLD(1), .CE_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .core_reset(core_reset_b), .core_ready(core_ready_b), .ce_cpu(ce_cpu_b),
    .lock_loss_cnt(lock_loss_cnt_b), .state(state_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic pl);
    logic used;
    int   go;
    rst = r;
    pll_locked = pl;
    @(posedge clk);
    if (r) begin
      p1 = 1'b0; p2 = 1'b0;
      for (int i = 0; i < 2; i++) begin run[i] = 0; llc[i] = 0; end
    end else begin
      used = p2; p2 = p1; p1 = pl;
      for (int i = 0; i < 2; i++) begin
        if (used) run[i]++;
        else begin
          if (run[i] >= ls_p[i] + 1 && llc[i] < 255) llc[i]++;
          run[i] = 0;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [1:0] es;
      logic       ece;
      go  = ls_p[i] + rh_p[i] + 1;
      es  = (run[i] == 0) ? 2'd0 : (run[i] <= ls_p[i]) ? 2'd1 : (run[i] < go) ? 2'd2 : 2'd3;
      ece = (run[i] > go) && (((run[i] - go) % cd_p[i]) == 0);
      if (i == 0) begin
        chk("a_state", {6'd0, state_a}, {6'd0, es});
        chk("a_core_reset", {7'd0, core_reset_a}, {7'd0, run[0] < go});
        chk("a_core_ready", {7'd0, core_ready_a}, {7'd0, run[0] >= go});
        chk("a_ce_cpu", {7'd0, ce_cpu_a}, {7'd0, ece});
        chk("a_lock_loss_cnt", lock_loss_cnt_a, 8'(llc[0]));
      end else begin
        chk("b_state", {6'd0, state_b}, {6'd0, es});
        chk("b_core_reset", {7'd0, core_reset_b}, {7'd0, run[1] < go});
        chk("b_core_ready", {7'd0, core_ready_b}, {7'd0, run[1] >= go});
        chk("b_ce_cpu", {7'd0, ce_cpu_b}, {7'd0, ece});
        chk("b_lock_loss_cnt", lock_loss_cnt_b, 8'(llc[1]));
      end
    end
  endtask

  initial begin
    int hi;
    p1 = 1'b0; p2 = 1'b0;
    for (int i = 0; i < 2; i++) begin run[i] = 0; llc[i] = 0; end
    rst = 1'b1;
    pll_locked = 1'b0;

    // Reset, then lock sampled at edge 1; directed timeline checks
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("reset_state", {6'd0, state_a}, 8'd0);
    chk("reset_core_reset", {7'd0, core_reset_a}, 8'd1);
    for (int e = 1; e <= 22; e++) begin
      step(1'b0, 1'b1);
      if (e == 3)  chk("t1_stab_edge3", {6'd0, state_a}, 8'd1);
      if (e == 7)  chk("t1_hold_edge7", {6'd0, state_a}, 8'd2);
      if (e == 8)  chk("t1_reset_edge8", {7'd0, core_reset_a}, 8'd1);
      if (e == 9)  chk("t1_release_edge9", {7'd0, core_reset_a}, 8'd0);
      if (e == 12) chk("t1_ce_edge12", {7'd0, ce_cpu_a}, 8'd0);
      if (e == 13) chk("t1_ce_edge13", {7'd0, ce_cpu_a}, 8'd1);
      if (e == 17) chk("t1_ce_edge17", {7'd0, ce_cpu_a}, 8'd1);
      if (e == 4)  chk("b_reset_edge4", {7'd0, core_reset_b}, 8'd1);
      if (e == 5)  chk("b_release_edge5", {7'd0, core_reset_b}, 8'd0);
      if (e == 6)  chk("b_ce_edge6", {7'd0, ce_cpu_b}, 8'd1);
    end

    // Drop lock in RUN, then re-lock and expect full qualification again
    for (int e = 1; e <= 3; e++) step(1'b0, 1'b0);
    chk("drop_state", {6'd0, state_a}, 8'd0);
    chk("drop_loss", lock_loss_cnt_a, 8'd1);
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, 1'b1);
      if (e == 8) chk("relock_reset_e8", {7'd0, core_reset_a}, 8'd1);
      if (e == 9) chk("relock_release_e9", {7'd0, core_reset_a}, 8'd0);
    end

    // Glitch during STABILIZE: restart, no loss counted
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) step(1'b0, 1'b1);
    chk("glitch_loss", lock_loss_cnt_a, 8'd0);

    // 300 losses landing in HOLD or RUN -> saturation
    for (int k = 0; k < 300; k++) begin
      hi = 5 + int'($urandom_range(0, 8));
      for (int j = 0; j < hi; j++) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    for (int j = 0; j < 4; j++) step(1'b0, 1'b1);
    chk("sat_loss", lock_loss_cnt_a, 8'd255);

    // One-cycle rst mid-RUN with lock held high
    for (int j = 0; j < 12; j++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("midrst_state", {6'd0, state_a}, 8'd0);
    chk("midrst_loss", lock_loss_cnt_a, 8'd0);
    for (int e = 1; e <= 10; e++) begin
      step(1'b0, 1'b1);
      if (e == 3) chk("midrst_stab_e3", {6'd0, state_a}, 8'd1);
      if (e == 9) chk("midrst_release_e9", {7'd0, core_reset_a}, 8'd0);
    end

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 79) == 0, $urandom_range(0, 11) != 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_reset_sequencer.md
Name: clk_reset_sequencer

Overview:
- Sits directly downstream of the core PLL wrapper, in the system clock domain (for example the 48 MHz output).
- Takes the PLL's asynchronous locked output and synchronises it, then requires it to stay high for a qualification period.
- Then holds the arcade core in reset for a fixed number of cycles before releasing it.
- While running, generates the periodic CPU clock-enable pulse; any loss of lock re-asserts core reset immediately.

Parameters:
- LOCK_STABLE, 256, cycles pll_locked must be continuously high (after sync) before reset hold begins; must be >= 1.
- RESET_HOLD, 16, cycles core_reset stays asserted after lock qualification; must be >= 1.
- CE_DIV, 8, ce_cpu period in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock (a PLL output).
- rst  in  1  synchronous active-high reset, e.g. user/OSD reset request.
- pll_locked  in  1  PLL locked flag, asynchronous to clk.
- core_reset  out  1  registered active-high reset to the arcade core.
- core_ready  out  1  high exactly when state is RUN; registered.
- ce_cpu  out  1  single-cycle CPU clock-enable pulse, only in RUN.
- lock_loss_cnt  out  8  saturating count of lock losses seen in HOLD or RUN.
- state  out  2  current state: 0 WAIT_LOCK, 1 STABILIZE, 2 HOLD, 3 RUN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; clock port is clk, reset port is rst.
- rst=1 dominates everything, including mid-operation. On that edge:
  - state=WAIT_LOCK, core_reset=1, core_ready=0, ce_cpu=0, lock_loss_cnt=0.
  - Both sync flops and all counters are cleared.
- Synchroniser:
  - Two-flop chain on pll_locked; locked_s is the second flop.
  - No glitch filtering beyond sampling; a single low sample counts as a loss.
- WAIT_LOCK: locked_s=1 -> STABILIZE with cnt=0; otherwise stay.
- STABILIZE:
  - locked_s=0 -> WAIT_LOCK; lock_loss_cnt unchanged.
  - Else, cnt==LOCK_STABLE-1 -> HOLD with cnt=0.
  - Else cnt+1.
- HOLD:
  - locked_s=0 -> WAIT_LOCK and lock_loss_cnt+1.
  - Else, cnt==RESET_HOLD-1 -> RUN with div=0.
  - Else cnt+1.
- RUN:
  - locked_s=0 -> WAIT_LOCK and lock_loss_cnt+1.
  - Else div increments, wrapping at CE_DIV-1 to 0.
- core_reset is registered as (next_state != RUN): it falls on the same edge RUN is entered and rises on the same edge RUN is left.
- Release latency: if pll_locked is sampled 1 at edge 1 and stays high, core_reset falls at edge 3+LOCK_STABLE+RESET_HOLD.
- ce_cpu:
  - Registered; high for one cycle when staying in RUN and div==CE_DIV-1.
  - First pulse is high in the cycle starting CE_DIV edges after core_reset falls; thereafter every CE_DIV cycles.
  - CE_DIV=1: ce_cpu is high on every cycle after RUN entry while in RUN.
  - Forced to 0 on the edge RUN is left.
- lock_loss_cnt saturates at 255 and does not wrap.
- Counter widths are $clog2 of the respective maximum, minimum 1 bit. Compare against an exact terminal value; no overflow is possible.
- pll_locked dropping and recovering between samples is invisible to the block; this is acceptable.

Test Plan:
- Params LOCK_STABLE=4, RESET_HOLD=2, CE_DIV=4. rst for 3 cycles, then pll_locked=1 sampled at edge 1:
  - state goes 0->1 at edge 3, 2 at edge 7, 3 at edge 9.
  - core_reset falls at edge 9; core_ready rises at edge 9.
  - ce_cpu is first high after edge 13, then after edges 17, 21, ...
- Same params, pll_locked low for one cycle during STABILIZE (locked_s low at edge 5):
  - state returns to 0 at edge 5; lock_loss_cnt stays 0.
  - Qualification restarts; core_reset stays 1 throughout.
- Drop pll_locked in RUN:
  - Two edges later state=0, core_reset=1, core_ready=0, ce_cpu=0, lock_loss_cnt=1.
  - Re-lock releases core_reset again after the full 3+4+2 edges.
- Toggle pll_locked 300 times with each loss landing in HOLD or RUN -> lock_loss_cnt reads 255 and holds.
- Assert rst for 1 cycle mid-RUN with pll_locked held high:
  - Next edge: state=0, core_reset=1, lock_loss_cnt=0.
  - Re-release follows the same edge-count timeline as the first test.
- CE_DIV=1, LOCK_STABLE=1, RESET_HOLD=1:
  - core_reset falls at edge 5.
  - ce_cpu is high every cycle after edge 6 until lock loss.
